// File: rtl/me1_addrphase_t.sv
// me1_addrphase_t: address-phase stage of load/store port 2.
// Register A holds the op currently presented on the AHB-Lite address phase;
// register D (r_me2_*) holds the op whose data phase ME2 is running.
//
// Handshake: ex_valid/ex_ready is a strict valid/ready pair. An op moves on a
// rising edge where both are high; ex_ready never depends on ex_valid, and
// upstream keeps the op stable while ex_valid is high and ex_ready is low.
module me1_addrphase_t #(
  parameter logic [3:0] HPROT_VAL = 4'h1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic [31:0] ldst2_ahb_HADDR,
  output logic [1:0]  ldst2_ahb_HTRANS,
  output logic        ldst2_ahb_HWRITE,
  output logic [2:0]  ldst2_ahb_HSIZE,
  output logic [2:0]  ldst2_ahb_HBURST,
  output logic [3:0]  ldst2_ahb_HPROT,
  input  logic        ldst2_ahb_HREADY,
  input  logic        ldst2_ahb_HRESP,
  output logic [1:0]  r_me2_alu_Q,
  output logic [3:0]  r_me2_memop_Q,
  output logic [31:0] r_me2_wtdat_Q,
  output logic        me1_misalign,
  output logic        me1_buserr
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_ERR2 = 1'b1;

  logic [0:0]  state;

  // Address-phase register A
  logic        a_valid;
  logic [31:0] a_addr;
  logic [3:0]  a_memop;
  logic [31:0] a_wdata;
  logic [1:0]  a_size;
  logic        a_write;

  // Decode of the incoming op
  logic        op_ok;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_misalign;
  logic [31:0] op_lane;
  logic        accept;
  logic        load_a;
  logic        err_start;

  // Classify the incoming memop; undefined encodings behave like "none".
  always_comb begin
    op_ok    = 1'b1;
    op_store = 1'b0;
    op_size  = 2'd0;
    case (ex_memop)
      4'h1: begin op_store = 1'b1; op_size = 2'd0; end
      4'h2: begin op_store = 1'b1; op_size = 2'd1; end
      4'h3: begin op_store = 1'b1; op_size = 2'd2; end
      4'h9, 4'hA: op_size = 2'd0;
      4'hB, 4'hC: op_size = 2'd1;
      4'hD:       op_size = 2'd2;
      default:    op_ok = 1'b0;
    endcase
  end

  // Alignment by access size (halfword loads share the store rule) and
  // store-lane placement; loads carry no write data.
  always_comb begin
    op_misalign = 1'b0;
    if (op_ok) begin
      if (op_size == 2'd1) op_misalign = ex_addr[0];
      if (op_size == 2'd2) op_misalign = (ex_addr[1:0] != 2'b00);
    end
    op_lane = 32'd0;
    if (op_store) begin
      case (op_size)
        2'd0:    op_lane = {24'd0, ex_wdata[7:0]}  << {ex_addr[1:0], 3'b000};
        2'd1:    op_lane = {16'd0, ex_wdata[15:0]} << {ex_addr[1:0], 3'b000};
        default: op_lane = ex_wdata;
      endcase
    end
  end

  assign ex_ready  = (state == ST_RUN) && (!a_valid || ldst2_ahb_HREADY);
  assign accept    = ex_valid && ex_ready;
  assign load_a    = accept && op_ok && !op_misalign;
  assign err_start = (state == ST_RUN) && ldst2_ahb_HRESP && !ldst2_ahb_HREADY;

  // Error FSM: first HRESP cycle enters ERR2, the HREADY edge returns to RUN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                       state <= ST_RUN;
    else if (err_start)                             state <= ST_ERR2;
    else if (state == ST_ERR2 && ldst2_ahb_HREADY)  state <= ST_RUN;
  end

  // Register A: cancelled by an error, replaced on accept, emptied on advance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_valid <= 1'b0;
      a_addr  <= 32'd0;
      a_memop <= 4'd0;
      a_wdata <= 32'd0;
      a_size  <= 2'd0;
      a_write <= 1'b0;
    end else if (err_start) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid <= load_a;
      if (load_a) begin
        a_addr  <= ex_addr;
        a_memop <= ex_memop;
        a_wdata <= op_lane;
        a_size  <= op_size;
        a_write <= op_store;
      end
    end else if (ldst2_ahb_HREADY) begin
      a_valid <= 1'b0;
    end
  end

  // Register D: advances only on HREADY; an empty A or the end of an error
  // leaves a bubble (memop 0) for the data phase.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_me2_alu_Q   <= 2'd0;
      r_me2_memop_Q <= 4'd0;
      r_me2_wtdat_Q <= 32'd0;
    end else if (ldst2_ahb_HREADY) begin
      if (state == ST_RUN && a_valid) begin
        r_me2_alu_Q   <= a_addr[1:0];
        r_me2_memop_Q <= a_memop;
        r_me2_wtdat_Q <= a_wdata;
      end else begin
        r_me2_alu_Q   <= 2'd0;
        r_me2_memop_Q <= 4'd0;
        r_me2_wtdat_Q <= 32'd0;
      end
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      me1_misalign <= 1'b0;
      me1_buserr   <= 1'b0;
    end else begin
      me1_misalign <= accept && op_ok && op_misalign;
      me1_buserr   <= (state == ST_ERR2) && ldst2_ahb_HREADY;
    end
  end

  assign ldst2_ahb_HADDR  = a_addr;
  assign ldst2_ahb_HTRANS = a_valid ? 2'b10 : 2'b00;
  assign ldst2_ahb_HWRITE = a_write;
  assign ldst2_ahb_HSIZE  = {1'b0, a_size};
  assign ldst2_ahb_HBURST = 3'b000;
  assign ldst2_ahb_HPROT  = HPROT_VAL;

endmodule

// File: tb/tb_me1_addrphase_t.sv
// Bench for me1_addrphase_t: directed scenarios plus randomized ops with
// random wait states, checked against a reference model and a D-stage queue.
module tb_me1_addrphase_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic        hresp;
  logic [1:0]  d_alu;
  logic [3:0]  d_memop;
  logic [31:0] d_wdat;
  logic        me1_misalign;
  logic        me1_buserr;

  me1_addrphase_t dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_memop(ex_memop),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ldst2_ahb_HADDR(haddr), .ldst2_ahb_HTRANS(htrans), .ldst2_ahb_HWRITE(hwrite),
    .ldst2_ahb_HSIZE(hsize), .ldst2_ahb_HBURST(hburst), .ldst2_ahb_HPROT(hprot),
    .ldst2_ahb_HREADY(hready), .ldst2_ahb_HRESP(hresp),
    .r_me2_alu_Q(d_alu), .r_me2_memop_Q(d_memop), .r_me2_wtdat_Q(d_wdat),
    .me1_misalign(me1_misalign), .me1_buserr(me1_buserr)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [37:0] exp_q[$];     // expected {alu, memop, wdata} per D load
  bit          m_err, m_busy, hready_at_edge, exp_mis, exp_bus, acc_flag;
  logic [31:0] m_addr;
  logic [2:0]  m_hsize;
  logic        m_hwrite;
  logic [37:0] last_d;

  // Size in bytes (0 = no transfer), direction and lane-placed store data.
  task automatic classify(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output int unsigned bytes, output bit st, output logic [31:0] lane);
    logic [63:0] t;
    bytes = 0; st = 0;
    case (op)
      4'h1: begin bytes = 1; st = 1; end
      4'h2: begin bytes = 2; st = 1; end
      4'h3: begin bytes = 4; st = 1; end
      4'h9, 4'hA: bytes = 1;
      4'hB, 4'hC: bytes = 2;
      4'hD: bytes = 4;
      default: bytes = 0;
    endcase
    lane = 32'd0;
    if (st) begin
      if (bytes == 4) lane = wd;
      else begin
        t = (64'(wd) & ((64'd1 << (8 * bytes)) - 64'd1)) << (8 * (a % 4));
        lane = t[31:0];
      end
    end
  endtask

  always @(posedge CLK) begin
    int unsigned bytes;
    bit          st;
    logic [31:0] lane;
    bit          m_ready;
    hready_at_edge = hready;
    exp_mis = 0; exp_bus = 0; acc_flag = 0;
    if (!RST) begin
      m_err = 0; m_busy = 0;
      exp_q.delete();
    end else begin
      m_ready = !m_err && (!m_busy || hready);
      chk("ex_ready", ex_ready, m_ready);
      if (m_err) begin
        if (hready) begin m_err = 0; exp_bus = 1; end
      end else if (hresp && !hready) begin
        m_err = 1;
        if (m_busy && exp_q.size() > 0) void'(exp_q.pop_back());
        m_busy = 0;
      end else begin
        if (hready) m_busy = 0;
        if (ex_valid && m_ready) begin
          acc_flag = 1;
          classify(ex_memop, ex_addr, ex_wdata, bytes, st, lane);
          if (bytes != 0 && (ex_addr % bytes) != 0) exp_mis = 1;
          else if (bytes != 0) begin
            m_busy   = 1;
            m_addr   = ex_addr;
            m_hsize  = (bytes == 1) ? 3'd0 : (bytes == 2) ? 3'd1 : 3'd2;
            m_hwrite = st;
            exp_q.push_back({ex_addr[1:0], ex_memop, lane});
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [37:0] cur_d;
    cur_d = {d_alu, d_memop, d_wdat};
    if (!RST) last_d = 38'd0;
    else begin
      chk("htrans", htrans, m_busy ? 2'b10 : 2'b00);
      if (m_busy) chk("addr_phase", {haddr, hsize, hwrite}, {m_addr, m_hsize, m_hwrite});
      chk("misalign_pulse", me1_misalign, exp_mis);
      chk("buserr_pulse", me1_buserr, exp_bus);
      if (!hready_at_edge) chk("d_hold", cur_d, last_d);
      else if (d_memop != 4'd0) begin
        if (exp_q.size() == 0) chk("d_unexpected", cur_d, 38'd0);
        else chk("d_load", cur_d, exp_q.pop_front());
      end
      last_d = cur_d;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input logic r, input logic e);
    ex_valid = v; ex_memop = op; ex_addr = a; ex_wdata = wd;
    hready = r; hresp = e;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic rand_op();
    logic [3:0]  ops [10];
    logic [3:0]  op;
    logic [31:0] wd;
    bit          done;
    ops = '{4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h5};
    op = ops[$urandom_range(0, 9)];
    wd = $urandom();
    if (op == 4'h1) wd = wd & 32'hFF;
    if (op == 4'h2) wd = wd & 32'hFFFF;
    ex_valid = 1; ex_memop = op; ex_wdata = wd;
    ex_addr = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 3));
    done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      hready = ($urandom_range(0, 3) != 0); hresp = 0;
      @(posedge CLK); #1;
      done = acc_flag;
    end
    if (!done) chk("accept_timeout", 1'b0, 1'b1);
    ex_valid = 0;
    for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
      hready = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 0; ex_valid = 0; ex_memop = 0; ex_addr = 0; ex_wdata = 0;
    hready = 1; hresp = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_outputs", {haddr, htrans, hwrite, hsize}, 38'd0);
    chk("rst_d", {d_alu, d_memop, d_wdat}, 38'd0);
    chk("rst_pulses", {me1_misalign, me1_buserr}, 2'b00);
    chk("hburst", hburst, 3'b000);
    chk("hprot", hprot, 4'h1);
    RST = 1;
    idle(2);

    // LW word-aligned
    cyc(1'b1, 4'hD, 32'h1000_0008, 32'd0, 1'b1, 1'b0);
    chk("lw_addr", {haddr, htrans, hsize, hwrite}, {32'h1000_0008, 2'b10, 3'd2, 1'b0});
    cyc(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lw_d", {d_memop, d_alu}, {4'hD, 2'd0});
    idle(1);

    // SB to byte lane 3
    cyc(1'b1, 4'h1, 32'h0000_2003, 32'h0000_00A5, 1'b1, 1'b0);
    chk("sb_addr", {hsize, hwrite}, {3'd0, 1'b1});
    cyc(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("sb_d", {d_wdat, d_alu}, {32'hA500_0000, 2'd3});
    idle(1);

    // Back-to-back with two wait states on the SH data phase
    cyc(1'b1, 4'hA, 32'h01, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'h2, 32'h12, 32'h0000_BEEF, 1'b1, 1'b0);
    cyc(1'b1, 4'hD, 32'h20, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ex_valid = 0; hready = 0;
      #1;
      chk("b2b_wait_ready", ex_ready, 1'b0);
      chk("b2b_wait_haddr", haddr, 32'h20);
      @(posedge CLK); #1;
    end
    idle(3);

    // Misaligned SH
    cyc(1'b1, 4'h2, 32'h3001, 32'h0000_1234, 1'b1, 1'b0);
    chk("mis_pulse", me1_misalign, 1'b1);
    chk("mis_idle", htrans, 2'b00);
    cyc(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("mis_pulse_end", me1_misalign, 1'b0);
    chk("mis_d", d_memop, 4'd0);
    idle(1);

    // Two-cycle error response drops the queued LW
    cyc(1'b1, 4'h3, 32'h40, 32'h1122_3344, 1'b1, 1'b0);
    cyc(1'b1, 4'hD, 32'h44, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    hready = 1; hresp = 1;
    #1;
    chk("err2_idle", htrans, 2'b00);
    chk("err2_ready", ex_ready, 1'b0);
    @(posedge CLK); #1;
    chk("err_buserr", me1_buserr, 1'b1);
    chk("err_d_cleared", d_memop, 4'd0);
    hresp = 0;
    #1;
    chk("err_ready_back", ex_ready, 1'b1);
    idle(2);

    // Reset during a wait state
    cyc(1'b1, 4'hD, 32'h50, 32'd0, 1'b1, 1'b0);
    ex_valid = 0; hready = 0;
    @(posedge CLK); #1;
    chk("pre_rst_nonseq", htrans, 2'b10);
    #2 RST = 0;
    #1;
    chk("async_rst_bus", {haddr, htrans, hwrite, hsize}, 38'd0);
    chk("async_rst_d", {d_alu, d_memop, d_wdat}, 38'd0);
    @(posedge CLK); #1;
    RST = 1; hready = 1;
    idle(2);

    // Randomized traffic with random wait states
    for (int n = 0; n < 300; n++) rand_op();
    idle(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/me1_addrphase_t.md
Name: me1_addrphase_t

Overview:
- Address-phase stage of load/store port 2, sitting directly upstream of the ME2 data-phase stage.
- Accepts one memory operation per cycle from the execute stage and drives the AHB-Lite address phase on ldst2_ahb.
- Owns the r_me2_alu, r_me2_memop and r_me2_wtdat pipeline registers that ME2 consumes in the data phase.
- Handles HREADY wait states, the two-cycle HRESP error response, and misaligned-access detection.

Parameters:
- HPROT_VAL, 4'h1, constant driven on HPROT (data access, user, non-bufferable, non-cacheable).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-low reset.
- ex_valid  input  1  upstream holds a valid memory operation.
- ex_ready  output  1  stage accepts the operation this cycle.
- ex_memop  input  4  0=none, 1=SB, 2=SH, 3=SW, 9=LB, A=LBU, B=LH, C=LHU, D=LW.
- ex_addr  input  32  effective address.
- ex_wdata  input  32  unaligned store data in bits [7:0]/[15:0]/[31:0].
- ldst2_ahb_HADDR  output  32  address-phase address, registered.
- ldst2_ahb_HTRANS  output  2  2'b00 IDLE, 2'b10 NONSEQ.
- ldst2_ahb_HWRITE  output  1  1 for stores.
- ldst2_ahb_HSIZE  output  3  0 byte, 1 half, 2 word.
- ldst2_ahb_HBURST  output  3  constant 3'b000 (SINGLE).
- ldst2_ahb_HPROT  output  4  constant HPROT_VAL.
- ldst2_ahb_HREADY  input  1  slave ready.
- ldst2_ahb_HRESP  input  1  slave error.
- r_me2_alu_Q  output  2  registered address[1:0] for the data phase.
- r_me2_memop_Q  output  4  registered memop for the data phase.
- r_me2_wtdat_Q  output  32  registered lane-aligned store data.
- me1_misalign  output  1  one-cycle pulse; the accepted op was misaligned.
- me1_buserr  output  1  one-cycle pulse on the second HRESP error cycle.

Behaviour:
- Structure: address-phase register A (valid, addr, memop, wdata) feeds data-phase register D (r_me2_*). All AHB address outputs are driven from A; HTRANS = A.valid ? NONSEQ : IDLE.
- Reset (async, RST=0) clears everything:
  - A.valid=0, HADDR=0, HTRANS=IDLE, HWRITE=0, HSIZE=0.
  - r_me2_alu_Q=0, r_me2_memop_Q=0, r_me2_wtdat_Q=0.
  - me1_misalign=0, me1_buserr=0, FSM=RUN.
  - Reset mid-transfer abandons the transfer silently.
- Handshake:
  - ex_ready = (FSM==RUN) && (!A.valid || HREADY).
  - An op is accepted on a rising edge where ex_valid && ex_ready.
  - memop=0 is accepted but loads nothing into A.
- Alignment: SH needs addr[0]=0; SW/LW need addr[1:0]=0. A misaligned op is accepted, is not loaded into A (no bus transfer), and pulses me1_misalign the following cycle.
- HSIZE: SB/LB/LBU=0, SH/LH/LHU=1, SW/LW=2. HWRITE=1 for memop 1..3.
- Store lane alignment: wdata is shifted left by 8*addr[1:0] (SB, SH) and truncated to 32 bits; SW passes through. Loads store wdata=0.
- A→D advance: on a rising edge with HREADY=1, D takes A's alu/memop/wdata when A.valid, else memop=0, alu=0, wdata=0.
  - Latency: op accepted at edge N → address phase during cycle N → D loaded at the first edge with HREADY=1 (edge N+1 with zero wait states).
- Wait states (HREADY=0): A and D hold; HADDR, HTRANS, HWRITE and HSIZE stay stable.
- Error FSM:
  - RUN → ERR2 on an edge with HRESP=1 && HREADY=0. On that edge A.valid is cleared so HTRANS=IDLE in the second error cycle; the cancelled op is dropped.
  - ERR2 → RUN on the next edge with HREADY=1. On that edge D clears to memop=0 and me1_buserr pulses for one cycle.
  - ex_ready=0 throughout ERR2.
- Simultaneous accept and advance: with HREADY=1, A is replaced by the new op on the same edge that D takes the old A (back-to-back throughput of 1 op/cycle).

Test Plan:
- Reset, then LW addr=0x1000_0008, HREADY=1 → next cycle HADDR=0x1000_0008, HTRANS=2, HSIZE=2, HWRITE=0; one cycle later r_me2_memop_Q=0xD, r_me2_alu_Q=0.
- SB addr=0x2003, wdata=0x0000_00A5 → HSIZE=0, HWRITE=1; then r_me2_wtdat_Q=0xA500_0000, r_me2_alu_Q=3.
- Back-to-back LBU 0x01, SH 0x12, LW 0x20 with 2 wait states on the SH data phase → ex_ready=0 for 2 cycles, HADDR holds 0x20, all three ops reach D in order.
- SH addr=0x3001 → me1_misalign pulses once, HTRANS stays IDLE, r_me2_memop_Q=0.
- Error: HRESP=1, HREADY=0 then HRESP=1, HREADY=1 with a queued LW → HTRANS=IDLE in the second cycle, me1_buserr pulses, LW dropped, ex_ready re-asserts after.
- Assert RST during a wait state with HTRANS=NONSEQ → all outputs 0 and HTRANS=IDLE immediately, without waiting for CLK.
